// File: rtl/instr_sequencer.sv
// instr_sequencer: UM-32 execution controller.
// Fetches instruction words from array 0, latches them for the decoder,
// dispatches each one to its operator FSM and tracks the program counter.
// Optional feature macro: SEQ_WATCHDOG_EN (bounds the WAIT state to
// WDOG_CYCLES cycles, then faults).
// fetch_mem_in layout (mem_in_bus_t, 98 bits):
//   [97:96] mode, [95:64] array address, [63:32] offset, [31:0] data.
module instr_sequencer #(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] mem_out,
    output logic [97:0] fetch_mem_in,
    output logic        fetch_en,
    output logic [31:0] instr_word,
    output logic [13:0] fsm_reset,
    output logic [13:0] fsm_enable,
    input  logic [13:0] fsm_finished,
    input  logic        pc_load,
    input  logic [31:0] pc_load_value,
    output logic [31:0] pc,
    output logic        busy,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LATCH    = 3'd2,
        S_DISPATCH = 3'd3,
        S_WAIT     = 3'd4,
        S_RELEASE  = 3'd5,
        S_HALT     = 3'd6,
        S_FAULT    = 3'd7
    } state_t;

    localparam logic [3:0]  OP_HALT       = 4'd7;
    localparam logic [3:0]  OP_LAST_LEGAL = 4'd13;
    localparam logic [13:0] ALL_RESET     = 14'h3FFF;
    localparam logic [1:0]  MODE_READ     = 2'b00;

    state_t      state_r;
    logic        cap_valid_r;
    logic [31:0] cap_value_r;

`ifdef SEQ_WATCHDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
    logic [31:0] wdog_r;
`endif

    logic [3:0]  new_op_s;
    logic [13:0] new_onehot_s;
    logic        op_finished_s;
    logic [31:0] next_pc_s;

    // Decode the incoming word and derive the per-instruction helper values.
    always_comb begin
        new_op_s     = mem_out[31:28];
        new_onehot_s = 14'd0;
        if (new_op_s <= OP_LAST_LEGAL) begin
            new_onehot_s = 14'd1 << new_op_s;
        end else begin
            new_onehot_s = 14'd0;
        end
        // fsm_enable is one-hot on the active opcode during WAIT, so this
        // masks out every finished bit except the dispatched operator's.
        op_finished_s = |(fsm_finished & fsm_enable);
        if (cap_valid_r) begin
            next_pc_s = cap_value_r;
        end else begin
            next_pc_s = pc;
        end
    end

    // Sequencer FSM; every output is a register updated on state entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            pc           <= 32'd0;
            instr_word   <= 32'd0;
            fsm_reset    <= ALL_RESET;
            fsm_enable   <= 14'd0;
            fetch_en     <= 1'b0;
            fetch_mem_in <= 98'd0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            fault        <= 1'b0;
            cap_valid_r  <= 1'b0;
            cap_value_r  <= 32'd0;
`ifdef SEQ_WATCHDOG_EN
            wdog_r       <= 32'd0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r      <= S_FETCH;
                        pc           <= 32'd0;
                        busy         <= 1'b1;
                        fetch_en     <= 1'b1;
                        fetch_mem_in <= {MODE_READ, 32'h0, 32'h0, 32'h0};
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    // Read data appears one cycle after the request.
                    state_r      <= S_LATCH;
                    fetch_en     <= 1'b0;
                    fetch_mem_in <= 98'd0;
                end
                S_LATCH: begin
                    instr_word <= mem_out;
                    pc         <= pc + 32'd1;
                    if (new_op_s == OP_HALT) begin
                        state_r <= S_HALT;
                        halted  <= 1'b1;
                        busy    <= 1'b0;
                    end else if (new_op_s > OP_LAST_LEGAL) begin
                        state_r <= S_FAULT;
                        fault   <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state_r     <= S_DISPATCH;
                        fsm_reset   <= ~new_onehot_s;
                        fsm_enable  <= new_onehot_s;
                        cap_valid_r <= 1'b0;
                    end
                end
                S_DISPATCH: begin
                    state_r <= S_WAIT;
`ifdef SEQ_WATCHDOG_EN
                    wdog_r  <= 32'd0;
`endif
                end
                S_WAIT: begin
                    // Last pc_load seen in WAIT wins, including the finishing cycle.
                    if (pc_load) begin
                        cap_valid_r <= 1'b1;
                        cap_value_r <= pc_load_value;
                    end else begin
                        cap_valid_r <= cap_valid_r;
                    end
                    if (op_finished_s) begin
                        state_r    <= S_RELEASE;
                        fsm_reset  <= ALL_RESET;
                        fsm_enable <= 14'd0;
                    end else begin
`ifdef SEQ_WATCHDOG_EN
                        if (wdog_r >= WDOG_LAST) begin
                            state_r    <= S_FAULT;
                            fsm_reset  <= ALL_RESET;
                            fsm_enable <= 14'd0;
                            fault      <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            wdog_r <= wdog_r + 32'd1;
                        end
`else
                        state_r <= S_WAIT;
`endif
                    end
                end
                S_RELEASE: begin
                    state_r      <= S_FETCH;
                    pc           <= next_pc_s;
                    fetch_en     <= 1'b1;
                    fetch_mem_in <= {MODE_READ, 32'h0, next_pc_s, 32'h0};
                end
                S_HALT: begin
                    state_r    <= S_HALT;
                    fsm_reset  <= ALL_RESET;
                    fsm_enable <= 14'd0;
                    fetch_en   <= 1'b0;
                    busy       <= 1'b0;
                    halted     <= 1'b1;
                end
                S_FAULT: begin
                    state_r    <= S_FAULT;
                    fsm_reset  <= ALL_RESET;
                    fsm_enable <= 14'd0;
                    fetch_en   <= 1'b0;
                    busy       <= 1'b0;
                    fault      <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: park safely in FAULT.
                    state_r      <= S_FAULT;
                    fsm_reset    <= ALL_RESET;
                    fsm_enable   <= 14'd0;
                    fetch_en     <= 1'b0;
                    fetch_mem_in <= 98'd0;
                    busy         <= 1'b0;
                    fault        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer with a small array-0 memory model
// and a configurable operator-FSM model.
module tb_instr_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] mem_out;
    logic [97:0] fetch_mem_in;
    logic        fetch_en;
    logic [31:0] instr_word;
    logic [13:0] fsm_reset;
    logic [13:0] fsm_enable;
    logic [13:0] fsm_finished;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
    logic        fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:127];
    logic [15:0] fin_delay;
    logic        load_mode;
    logic [15:0] op_cnt;

    int cyc = 0;
    int overlap_cnt = 0;
    int decode_err = 0;
    bit mon_en = 1'b0;
    int fetch_count = 0;
    int last_fetch = 0;
    int spacing_err = 0;

    instr_sequencer #(.WDOG_CYCLES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .mem_out       (mem_out),
        .fetch_mem_in  (fetch_mem_in),
        .fetch_en      (fetch_en),
        .instr_word    (instr_word),
        .fsm_reset     (fsm_reset),
        .fsm_enable    (fsm_enable),
        .fsm_finished  (fsm_finished),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .pc            (pc),
        .busy          (busy),
        .halted        (halted),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read, data valid the cycle after the request.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fetch_en) mem_out <= mem[fetch_mem_in[38:32]];
    end

    // Operator model: counts cycles since its enable rose.
    always @(posedge clk) begin
        if (|fsm_enable) op_cnt <= op_cnt + 16'd1;
        else             op_cnt <= 16'd0;
    end

    assign fsm_finished  = ((|fsm_enable) && (op_cnt == fin_delay)) ? fsm_enable : 14'h0;
    assign pc_load       = load_mode && fsm_enable[12] && (op_cnt == 16'd1 || op_cnt == 16'd2);
    assign pc_load_value = (op_cnt == 16'd1) ? 32'h30 : 32'h10;

    // Bus-exclusivity, decode and fetch-spacing monitor.
    always @(negedge clk) begin
        if ($countones({fetch_en, fsm_enable}) > 1) overlap_cnt++;
        if ((|fsm_enable) && (fsm_enable != (14'd1 << instr_word[31:28]))) decode_err++;
        if (mon_en && fetch_en) begin
            if (fetch_count > 0 && (cyc - last_fetch) != 5) spacing_err++;
            last_fetch = cyc;
            fetch_count++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'h7000_0000;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fin_delay = 16'd1;
        load_mode = 1'b0;
        mem_out = 32'h0;
        clear_mem();
        do_reset();

        // Reset state
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_instr", instr_word, 32'h0);
        check_val("rst_fsm_reset", {18'h0, fsm_reset}, 32'h3FFF);
        check_val("rst_fsm_enable", {18'h0, fsm_enable}, 32'h0);
        check_val("rst_fetch", {30'h0, fetch_en, |fetch_mem_in}, 32'h0);
        check_val("rst_status", {29'h0, busy, halted, fault}, 32'h0);

        // cmov then halt
        mem[0] = 32'h0000_0062;
        mem[1] = 32'h7000_0000;
        pulse_start();
        check_val("f0_fetch_en", {31'h0, fetch_en}, 32'h1);
        check_val("f0_offset", fetch_mem_in[63:32], 32'h0);
        check_val("f0_mode_addr_data", {30'h0, |fetch_mem_in[97:64], |fetch_mem_in[31:0]}, 32'h0);
        check_val("f0_busy", {31'h0, busy}, 32'h1);
        tick(); // LATCH
        check_val("latch_fetch_en", {31'h0, fetch_en}, 32'h0);
        tick(); // DISPATCH
        check_val("disp_instr", instr_word, 32'h0000_0062);
        check_val("disp_pc", pc, 32'h1);
        check_val("disp_enable", {18'h0, fsm_enable}, 32'h0001);
        check_val("disp_reset", {18'h0, fsm_reset}, 32'h3FFE);
        tick(); // WAIT (finishes here)
        check_val("wait_enable", {18'h0, fsm_enable}, 32'h0001);
        tick(); // RELEASE
        check_val("rel_enable", {18'h0, fsm_enable}, 32'h0);
        check_val("rel_reset", {18'h0, fsm_reset}, 32'h3FFF);
        check_val("rel_busy", {31'h0, busy}, 32'h1);
        tick(); // FETCH
        check_val("f1_offset", fetch_mem_in[63:32], 32'h1);
        tick(); // LATCH
        tick(); // HALT
        check_val("halt_halted", {31'h0, halted}, 32'h1);
        check_val("halt_pc", pc, 32'h2);
        check_val("halt_busy", {31'h0, busy}, 32'h0);
        pulse_start();
        tick();
        check_val("halt_sticky", {29'h0, busy, halted, fetch_en}, 32'h2);

        // Illegal opcode
        do_reset();
        check_val("rst_clears_halt", {31'h0, halted}, 32'h0);
        mem[0] = 32'hE000_0000;
        pulse_start();
        tick();
        tick();
        check_val("fault_flag", {31'h0, fault}, 32'h1);
        check_val("fault_enable", {18'h0, fsm_enable}, 32'h0);
        check_val("fault_reset", {18'h0, fsm_reset}, 32'h3FFF);
        check_val("fault_instr", instr_word, 32'hE000_0000);
        pulse_start();
        tick();
        check_val("fault_sticky", {29'h0, busy, fault, fetch_en}, 32'h2);

        // Opcode 12 with pc_load (last capture wins)
        do_reset();
        clear_mem();
        mem[0] = 32'hC000_0000;
        fin_delay = 16'd2;
        load_mode = 1'b1;
        pulse_start();
        tick(); // LATCH
        tick(); // DISPATCH
        check_val("ld_enable", {18'h0, fsm_enable}, 32'h1000);
        tick(); // WAIT1
        tick(); // WAIT2
        check_val("ld_pc_hold", pc, 32'h1);
        tick(); // RELEASE
        tick(); // FETCH
        check_val("ld_offset", fetch_mem_in[63:32], 32'h10);
        check_val("ld_pc", pc, 32'h10);
        tick();
        tick();
        check_val("ld_halt_pc", {halted, pc[30:0]}, 32'h8000_0011);
        load_mode = 1'b0;
        fin_delay = 16'd1;

        // 100 instructions, 5-cycle spacing, no bus overlap
        do_reset();
        for (int i = 0; i < 100; i++) begin
            int op;
            op = i % 13;
            if (op >= 7) op = op + 1;
            mem[i] = {op[3:0], 28'h0};
        end
        mem[100] = 32'h7000_0000;
        mon_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 1000 && !halted; i++) tick();
        mon_en = 1'b0;
        check_val("run_halted", {31'h0, halted}, 32'h1);
        check_val("run_pc", pc, 32'd101);
        check_val("run_fetches", fetch_count, 32'd101);
        check_val("run_spacing", spacing_err, 32'd0);
        check_val("run_overlap", overlap_cnt, 32'd0);
        check_val("run_decode", decode_err, 32'd0);

        // Reset in the middle of WAIT for opcode 1
        do_reset();
        clear_mem();
        mem[0] = 32'h1000_0000;
        fin_delay = 16'hFFFF;
        pulse_start();
        tick();
        tick();
        tick();
        tick(); // still waiting
        check_val("mw_enable_pre", {18'h0, fsm_enable}, 32'h0002);
        reset = 1'b1;
        #1;
        check_val("mw_enable", {18'h0, fsm_enable}, 32'h0);
        check_val("mw_reset", {18'h0, fsm_reset}, 32'h3FFF);
        check_val("mw_pc_busy", {busy, pc[30:0]}, 32'h0);
        tick();
        reset = 1'b0;

        // Operator that never finishes
        mem[0] = 32'h2000_0000;
        pulse_start();
        tick();
        tick(); // DISPATCH
`ifdef SEQ_WATCHDOG_EN
        repeat (8) tick(); // 8 WAIT cycles
        check_val("wd_not_yet", {31'h0, fault}, 32'h0);
        tick();
        check_val("wd_fault", {31'h0, fault}, 32'h1);
        check_val("wd_enable", {18'h0, fsm_enable}, 32'h0);
        check_val("wd_reset", {18'h0, fsm_reset}, 32'h3FFF);
`else
        repeat (40) tick();
        check_val("nowd_busy", {30'h0, busy, fault}, 32'h2);
        check_val("nowd_enable", {18'h0, fsm_enable}, 32'h0004);
`endif
        check_val("final_overlap", overlap_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Top-level UM-32 execution controller: fetches instruction words from array 0 through `mem_sys`, latches them for `instr_decoder`, and dispatches each to its operator FSM (`cmov_fsm`, `addr_idx_fsm`, …). It holds every operator FSM in reset except the one selected, owns the one-hot bus-buffer enables that share `reg_in_bus` and `mem_in` between requesters, and tracks the program counter. Halt and illegal opcodes are terminal states.

## Interface
Parameters:
- `WDOG_CYCLES`, 1024: max cycles in WAIT before fault (used only with `SEQ_WATCHDOG_EN`).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse; begins execution at pc 0 from IDLE.
- `mem_out`  in  32  read data from `mem_sys`, valid one cycle after request.
- `fetch_mem_in`  out  mem_in_bus_t  fetch request toward `mem_in_bus_buf`.
- `fetch_en`  out  1  enable for the fetch `mem_in_bus_buf`.
- `instr_word`  out  32  latched instruction to `instr_decoder`.
- `fsm_reset`  out  14  per-opcode active-high reset to operator FSMs.
- `fsm_enable`  out  14  per-opcode bus-buffer enables; one-hot or zero.
- `fsm_finished`  in  14  per-opcode `finished` from operator FSMs.
- `pc_load`  in  1  load-program FSM requests pc replacement.
- `pc_load_value`  in  32  new pc (register C value).
- `pc`  out  32  current program counter.
- `busy`, `halted`, `fault`  out  1 each  status.

## Operation
- States: IDLE, FETCH, LATCH, DISPATCH, WAIT, RELEASE, HALT, FAULT.
- IDLE: `start`=1 → FETCH, pc←0.
- FETCH (1 cycle): `fetch_en`=1; `fetch_mem_in` = {mode 2'b00 read, address 32'h0, offset pc, data 0}.
- LATCH (1 cycle): `instr_word`←`mem_out`; pc←pc+1 (32-bit wrap, 0xFFFFFFFF→0). Opcode = `mem_out[31:28]`. Opcode 7 → HALT; 14/15 → FAULT; else → DISPATCH.
- DISPATCH (1 cycle): `fsm_reset[op]`←0, `fsm_enable[op]`←1; all other bits stay reset=1, enable=0.
- WAIT: hold until `fsm_finished[op]`=1, then → RELEASE. `fsm_finished` ignored outside WAIT and for bits ≠ op. `pc_load`=1 in any WAIT cycle captures `pc_load_value`; last capture wins.
- RELEASE (1 cycle): `fsm_reset[op]`←1, `fsm_enable[op]`←0; pc←captured value if a capture occurred, else unchanged; → FETCH.
- HALT: `halted`=1, sticky until `reset`. FAULT: `fault`=1, sticky until `reset`. Neither state dispatches; all FSMs held in reset.
- Bus exclusivity: `fetch_en` and all `fsm_enable` bits never high together; at most one bit high in any cycle.
- `start` ignored outside IDLE.
- `busy`=1 in FETCH..RELEASE.

## Timing
- All outputs registered. Reset values: state IDLE, `pc`=0, `instr_word`=0, `fsm_reset`=14'h3FFF, `fsm_enable`=0, `fetch_en`=0, `fetch_mem_in`=0, `busy`/`halted`/`fault`=0.
- Instruction overhead: 4 cycles + WAIT length; operator finishing in its first WAIT cycle gives 5 cycles/instruction.
- `reset` mid-operation: immediate return to reset values; operator FSMs forced into reset same cycle via `fsm_reset`.
- `pc_load` in RELEASE or later is ignored.

## Configuration
- `SEQ_WATCHDOG_EN` defined: counter clears on DISPATCH, increments each WAIT cycle; reaching `WDOG_CYCLES` without `fsm_finished[op]` → FAULT (op FSM re-reset, enable dropped). `finished` and timeout in same cycle: `finished` wins.
- Undefined: no counter; WAIT may last indefinitely.

## Test plan
- Array 0 = {32'h0000_0062 (cmov A=1,B=4,C=2), 32'h7000_0000}, r2=1, r4=0x5555; `start` → `fsm_enable[0]` high from DISPATCH, r1=0x5555 after cycle ~5, then `halted`=1, pc=2.
- Word 32'hE000_0000 at offset 0 → `fault`=1 after LATCH, all `fsm_enable`=0, `fsm_reset`=14'h3FFF.
- Opcode 12 with model FSM pulsing `pc_load`, `pc_load_value`=0x10 → next FETCH offset 0x10, not 1.
- Model FSM returns `finished` on first WAIT cycle → 5-cycle instruction spacing; `fetch_en` and `fsm_enable` never overlap across 100 instructions.
- `reset` asserted mid-WAIT of opcode 1 → same cycle `fsm_enable`=0, `fsm_reset[1]`=1, `pc`=0, state IDLE.
- With `SEQ_WATCHDOG_EN`, `WDOG_CYCLES`=8, FSM never finishes → `fault`=1 after 8 WAIT cycles; without macro, `busy` stays 1.
